// File: rtl/game_pkg.sv
// Shared command codes, scheduler state encodings and widths for the turn scheduler slice.
package game_pkg;

  localparam int unsigned CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_UP     = 3'd0,
    CMD_DOWN   = 3'd1,
    CMD_LEFT   = 3'd2,
    CMD_RIGHT  = 3'd3,
    CMD_SELECT = 3'd4,
    CMD_HALF   = 3'd5,
    CMD_FWD    = 3'd6,
    CMD_END    = 3'd7
  } cmd_t;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE   = 2'd0;
  localparam sched_state_t ST_TURN   = 2'd1;
  localparam sched_state_t ST_DRAIN  = 2'd2;
  localparam sched_state_t ST_SWITCH = 2'd3;

endpackage

// File: rtl/turn_scheduler_if.sv
// Keyboard input, game-logic command handshake and turn status bundle.
interface turn_scheduler_if;

  logic                      keyboard_locker;
  logic [game_pkg::CMD_W-1:0] keyboard_data;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [game_pkg::CMD_W-1:0] cmd_data;
  logic                      cmd_player;
  logic                      turn_player;
  logic [7:0]                time_left;
  logic [15:0]               turn_count;
  logic                      overflow;

  modport master (
    input  keyboard_locker, keyboard_data, cmd_ready,
    output cmd_valid, cmd_data, cmd_player, turn_player, time_left, turn_count, overflow
  );

  modport slave (
    output keyboard_locker, keyboard_data, cmd_ready,
    input  cmd_valid, cmd_data, cmd_player, turn_player, time_left, turn_count, overflow
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; wrap-bit pointers, a pop frees room for a same-cycle push when full.
module cmd_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // status flags, accepted push/pop and head read
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout    = mem[rd_ptr[AW-1:0]];
  end

  // pointer advance, flush returns both pointers to zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/turn_scheduler.sv
// Buffers keyboard commands and forwards them to the game logic one turn at a time,
// alternating players on end-turn key, move limit or timeout.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 50_000_000,
  parameter int unsigned TURN_SECONDS = 15,
  parameter int unsigned MAX_MOVES    = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic              clock,
  input logic              reset_n,
  input logic              start,
  turn_scheduler_if.master sched
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned MW = $clog2(MAX_MOVES + 1);

  sched_state_t     state;
  logic             lock_q;
  logic [PW-1:0]    presc;
  logic [MW-1:0]    moves;
  logic             in_turn;
  logic             rise;
  logic             push;
  logic             pop;
  logic             xfer;
  logic             tick;
  logic             head_end;
  logic             end_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_dout;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (state == ST_SWITCH),
    .din     (sched.keyboard_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // previous locker level for rising-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lock_q <= 1'b0;
    else          lock_q <= sched.keyboard_locker;
  end

  // capture, output-slot load, timer tick and the merged turn-end request
  always_comb begin
    in_turn  = (state == ST_TURN);
    rise     = sched.keyboard_locker & ~lock_q;
    push     = rise & in_turn;
    xfer     = sched.cmd_valid & sched.cmd_ready;
    pop      = in_turn & (~sched.cmd_valid | sched.cmd_ready) & ~fifo_empty;
    head_end = (cmd_t'(fifo_dout) == CMD_END);
    tick     = in_turn & (presc == PW'(TICK_CYCLES - 1));
    end_req  = (pop & head_end)
             | (in_turn & xfer & (moves == MW'(MAX_MOVES - 1)))
             | (tick & (sched.time_left <= 8'd1));
  end

  // turn sequencing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state <= ST_TURN;
        ST_TURN:   if (end_req) state <= ST_DRAIN;
        ST_DRAIN:  if (!sched.cmd_valid) state <= ST_SWITCH;
        default:   state <= ST_TURN;
      endcase
    end
  end

  // turn owner, countdown timer, move count, overflow flag and turn counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sched.turn_player <= 1'b0;
      sched.time_left   <= '0;
      sched.turn_count  <= '0;
      sched.overflow    <= 1'b0;
      presc             <= '0;
      moves             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sched.turn_player <= 1'b0;
            sched.time_left   <= 8'(TURN_SECONDS);
          end
        end
        ST_TURN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick && sched.time_left != '0) sched.time_left <= sched.time_left - 1'b1;
          if (xfer) moves <= moves + 1'b1;
          if (push && fifo_full && !pop) sched.overflow <= 1'b1;
        end
        ST_SWITCH: begin
          sched.turn_player <= ~sched.turn_player;
          sched.time_left   <= 8'(TURN_SECONDS);
          sched.turn_count  <= sched.turn_count + 1'b1;
          sched.overflow    <= 1'b0;
          presc             <= '0;
          moves             <= '0;
        end
        default: ;
      endcase
    end
  end

  // output register: an END_TURN head is consumed without being offered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sched.cmd_valid  <= 1'b0;
      sched.cmd_data   <= '0;
      sched.cmd_player <= 1'b0;
    end else if (pop && !head_end) begin
      sched.cmd_valid  <= 1'b1;
      sched.cmd_data   <= fifo_dout;
      sched.cmd_player <= sched.turn_player;
    end else if (xfer || (pop && head_end)) begin
      sched.cmd_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_turn_scheduler;

  localparam int unsigned TICK  = 4;
  localparam int unsigned TSEC  = 3;
  localparam int unsigned MAXM  = 2;
  localparam int unsigned DEPTH = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic start   = 1'b0;

  turn_scheduler_if bus ();

  turn_scheduler #(
    .TICK_CYCLES  (TICK),
    .TURN_SECONDS (TSEC),
    .MAX_MOVES    (MAXM),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .sched   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int seen3   = 0;

  // reference model: mode 0 idle, 1 turn, 2 drain, 3 switch
  int          m_mode;
  bit [2:0]    m_q[$];
  bit          m_lock;
  bit          m_valid;
  bit [2:0]    m_data;
  bit          m_player;
  bit          m_tp;
  bit          m_ovf;
  int unsigned m_time;
  int unsigned m_presc;
  int unsigned m_moves;
  bit [15:0]   m_count;

  task automatic check(input string tag, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_q.delete(); m_lock = 0; m_valid = 0; m_data = 0; m_player = 0;
    m_tp = 0; m_ovf = 0; m_time = 0; m_presc = 0; m_moves = 0; m_count = 0;
  endfunction

  function automatic void model_step(input bit st, input bit lk, input bit [2:0] kd, input bit rdy);
    bit       rise;
    bit       xfer;
    bit       endr;
    bit [2:0] h;
    rise   = lk && !m_lock;
    m_lock = lk;
    xfer   = m_valid && rdy;
    endr   = 0;
    case (m_mode)
      0: if (st) begin m_mode = 1; m_time = TSEC; m_tp = 0; end
      1: begin
        if ((!m_valid || rdy) && m_q.size() > 0) begin
          h = m_q.pop_front();
          if (h == 3'd7) begin endr = 1; m_valid = 0; end
          else begin m_valid = 1; m_data = h; m_player = m_tp; end
        end else if (xfer) m_valid = 0;
        if (rise) begin
          if (m_q.size() < DEPTH) m_q.push_back(kd);
          else m_ovf = 1;
        end
        if (xfer) begin m_moves++; if (m_moves == MAXM) endr = 1; end
        if (m_presc == TICK - 1) begin
          m_presc = 0;
          if (m_time > 0) m_time--;
          if (m_time == 0) endr = 1;
        end else m_presc++;
        if (endr) m_mode = 2;
      end
      2: begin
        if (!m_valid) m_mode = 3;
        if (xfer) m_valid = 0;
      end
      default: begin
        m_q.delete(); m_tp = !m_tp; m_time = TSEC; m_presc = 0; m_moves = 0;
        m_ovf = 0; m_count = m_count + 16'd1; m_mode = 1;
      end
    endcase
  endfunction

  task automatic compare_all();
    check("cmd_valid",   bus.cmd_valid,   m_valid);
    check("cmd_data",    bus.cmd_data,    m_data);
    check("cmd_player",  bus.cmd_player,  m_player);
    check("turn_player", bus.turn_player, m_tp);
    check("time_left",   bus.time_left,   m_time);
    check("turn_count",  bus.turn_count,  m_count);
    check("overflow",    bus.overflow,    m_ovf);
  endtask

  task automatic tick_clk();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step(start, bus.keyboard_locker, bus.keyboard_data, bus.cmd_ready);
    #1;
    compare_all();
    if (bus.cmd_valid && bus.cmd_data == 3'd3) seen3++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick_clk();
    reset_n = 1'b1;
  endtask

  task automatic begin_game();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
  endtask

  task automatic send(input bit [2:0] code);
    bus.keyboard_locker = 1'b1;
    bus.keyboard_data   = code;
    tick_clk();
    bus.keyboard_locker = 1'b0;
    tick_clk();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.keyboard_locker = 1'b0;
    bus.keyboard_data   = 3'd0;
    bus.cmd_ready       = 1'b0;
    model_reset();
    #2;
    do_reset();
    check("rst_valid", bus.cmd_valid, 0);
    check("rst_count", bus.turn_count, 0);

    // first-command latency
    begin_game();
    check("start_time", bus.time_left, TSEC);
    bus.cmd_ready = 1'b1; bus.keyboard_locker = 1'b1; bus.keyboard_data = 3'd2;
    tick_clk();
    check("lat_early_valid", bus.cmd_valid, 0);
    bus.keyboard_locker = 1'b0;
    tick_clk();
    check("lat_valid", bus.cmd_valid, 1);
    check("lat_data", bus.cmd_data, 2);
    check("lat_player", bus.cmd_player, 0);

    // move limit switches the turn and flushes a late command
    do_reset();
    begin_game();
    bus.cmd_ready = 1'b1;
    seen3 = 0;
    send(3'd0); send(3'd1); send(3'd3);
    for (int k = 0; k < 6 && bus.turn_count != 16'd1; k++) tick_clk();
    check("maxmv_count", bus.turn_count, 1);
    check("maxmv_player", bus.turn_player, 1);
    check("maxmv_time", bus.time_left, TSEC);
    for (int k = 0; k < 3; k++) tick_clk();
    check("maxmv_flushed", seen3, 0);

    // END_TURN key is consumed and ends the turn
    do_reset();
    begin_game();
    bus.cmd_ready = 1'b1; bus.keyboard_locker = 1'b1; bus.keyboard_data = 3'd7;
    tick_clk();
    bus.keyboard_locker = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick_clk();
      check("end_no_valid", bus.cmd_valid, 0);
    end
    check("end_player", bus.turn_player, 1);
    check("end_count", bus.turn_count, 1);

    // timeout countdown
    do_reset();
    begin_game();
    for (int k = 1; k <= 12; k++) begin
      tick_clk();
      check("timer_step", bus.time_left, TSEC - k / TICK);
    end
    for (int k = 0; k < 4 && bus.turn_count != 16'd1; k++) tick_clk();
    check("timeout_count", bus.turn_count, 1);
    check("timeout_reload", bus.time_left, TSEC);

    // asynchronous reset mid-turn with a command pending
    bus.cmd_ready = 1'b0;
    send(3'd4); send(3'd5);
    check("pre_rst_valid", bus.cmd_valid, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", bus.cmd_valid, 0);
    check("arst_data", bus.cmd_data, 0);
    check("arst_player", bus.turn_player, 0);
    check("arst_time", bus.time_left, 0);
    check("arst_count", bus.turn_count, 0);
    tick_clk();
    reset_n = 1'b1;
    bus.cmd_ready = 1'b1;
    begin_game();
    for (int k = 0; k < 3; k++) begin
      tick_clk();
      check("arst_fifo_empty", bus.cmd_valid, 0);
    end

    // back-pressure, overflow and drain
    do_reset();
    begin_game();
    bus.cmd_ready = 1'b0;
    for (int c = 1; c <= 6; c++) send(3'(c));
    check("ovf_set", bus.overflow, 1);
    check("ovf_time", bus.time_left, 0);
    for (int k = 0; k < 5; k++) begin
      tick_clk();
      check("drain_hold_data", bus.cmd_data, 1);
      check("drain_hold_count", bus.turn_count, 0);
    end
    bus.cmd_ready = 1'b1;
    for (int k = 0; k < 5 && bus.turn_count != 16'd1; k++) tick_clk();
    check("drain_count", bus.turn_count, 1);
    check("ovf_cleared", bus.overflow, 0);
    for (int k = 0; k < 3; k++) tick_clk();
    check("drain_flushed", bus.cmd_valid, 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        start = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 1) == 1) bus.keyboard_locker = ~bus.keyboard_locker;
        bus.keyboard_data = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        if ((i % 300) < 80) bus.cmd_ready = ($urandom_range(0, 7) == 0);
        else bus.cmd_ready = ($urandom_range(0, 3) != 0);
        tick_clk();
      end
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
